// File: rtl/pulse_interval_timer.sv
// Measures the clock-cycle interval between a start pulse and a stop pulse and
// holds the result until acknowledged. Define PULSE_INTERVAL_TIMER_TIMEOUT_EN to abandon runs at TIMEOUT.
module pulse_interval_timer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start,
  input  logic             i_Stop,
  input  logic             i_Ack,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Valid,
  output logic             o_Busy,
  output logic             o_Timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // An out-of-range TIMEOUT could never match the counter, so refuse to elaborate.
  if (TIMEOUT < 2 || longint'(TIMEOUT) > longint'(CNT_MAX)) begin : g_bad_timeout
    $error("pulse_interval_timer: TIMEOUT out of range for CNT_W");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             busy_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_inc;

  // The value the counter would take on this edge; it is also the result on a stop.
  always_comb begin
`ifdef PULSE_INTERVAL_TIMER_TIMEOUT_EN
    cnt_inc = cnt_q + CNT_W'(1);
`else
    cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
`endif
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A stop coincident with the start is meaningless and is dropped.
          if (i_Start) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (i_Stop) begin
            count_q   <= cnt_inc;
            timeout_q <= 1'b0;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
`ifdef PULSE_INTERVAL_TIMER_TIMEOUT_EN
          end else if (cnt_inc == TIMEOUT_C) begin
            count_q   <= TIMEOUT_C;
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
`endif
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        DONE: begin
          // Result is frozen; only the acknowledge moves us on, and a start
          // arriving with it is not a new run.
          if (i_Ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_Count   = count_q;
  assign o_Valid   = valid_q;
  assign o_Busy    = busy_q;
  assign o_Timeout = timeout_q;

endmodule

// File: doc/pulse_interval_timer.md
PULSE_INTERVAL_TIMER -- requirements
Module: pulse_interval_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the interval counter and result.
REQ-002 SHALL have parameter TIMEOUT, default 50000, the cycle count after which a measurement is abandoned; legal range 2..2^CNT_W-1.
REQ-003 SHALL have port i_Clk  input  1  the single clock, rising-edge active.
REQ-004 SHALL have port i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_Start  input  1  start pulse, one cycle wide, from the upstream level-to-pulse stage on the launch line.
REQ-006 SHALL have port i_Stop  input  1  stop pulse, one cycle wide, from the upstream level-to-pulse stage on the receive line.
REQ-007 SHALL have port i_Ack  input  1  consumer acknowledge of a presented result.
REQ-008 SHALL have port o_Count  output  CNT_W  measured interval in clock cycles.
REQ-009 SHALL have port o_Valid  output  1  result on o_Count/o_Timeout is valid.
REQ-010 SHALL have port o_Busy  output  1  a measurement is in progress.
REQ-011 SHALL have port o_Timeout  output  1  the presented result ended by timeout, not by stop.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; o_Busy=1 only in RUN, o_Valid=1 only in DONE, both registered.
REQ-013 IDLE: i_Start=1 at edge k SHALL clear the internal counter to 0 and enter RUN; i_Stop in IDLE, including the same cycle as i_Start, SHALL be ignored.
REQ-014 RUN: each edge without i_Stop SHALL increment the counter by 1.
REQ-015 RUN: i_Stop=1 at edge k+N SHALL load o_Count=N (counter+1), clear o_Timeout, and enter DONE; minimum result is 1.
REQ-016 i_Start in RUN or DONE SHALL be ignored; no restart, no result change.
REQ-017 DONE: o_Count, o_Timeout and o_Valid SHALL hold until i_Ack=1 is sampled, then return to IDLE with o_Valid=0 on the next cycle.
REQ-018 i_Ack outside DONE SHALL be ignored; i_Start in the same cycle as accepting i_Ack SHALL be ignored.
REQ-019 i_Stop in DONE SHALL be ignored.
REQ-020 o_Count SHALL change only on entry to DONE; it holds its last value in IDLE and RUN.

Reset
REQ-021 i_Rst_n=0 SHALL, asynchronously, force state IDLE, counter 0, o_Count=0, o_Valid=0, o_Busy=0, o_Timeout=0.
REQ-022 Reset asserted mid-RUN or in DONE SHALL abort the measurement with no result presented; first i_Start is accepted at the first rising edge after i_Rst_n releases.

Configuration
REQ-023 Macro PULSE_INTERVAL_TIMER_TIMEOUT_EN SHALL select the timeout feature.
REQ-024 With the macro defined: in RUN, when counter+1 equals TIMEOUT and i_Stop=0, the block SHALL load o_Count=TIMEOUT, set o_Timeout=1, and enter DONE; i_Stop on that same edge wins (o_Timeout=0, o_Count=TIMEOUT).
REQ-025 Without the macro: TIMEOUT SHALL be unused; the counter SHALL saturate at 2^CNT_W-1 and RUN persists until i_Stop, which yields o_Count=2^CNT_W-1 once saturated; o_Timeout SHALL be constant 0.

Verification (CNT_W=16, TIMEOUT=100, clock 20 ns)
REQ-026 Start pulse at edge 10, stop pulse at edge 47 -> o_Busy high edges 10..47, o_Valid=1 after edge 47, o_Count=37, o_Timeout=0; held until i_Ack, o_Valid=0 one cycle after ack.
REQ-027 Start at edge 5, stop at edge 6 -> o_Count=1; start and stop together in IDLE -> RUN entered, o_Busy=1, no result until a later stop.
REQ-028 Macro defined, start with no stop -> o_Valid=1 after 100 cycles, o_Count=100, o_Timeout=1; stop on the 100th edge -> o_Timeout=0, o_Count=100.
REQ-029 Macro undefined, CNT_W=4, start, stop after 20 cycles -> o_Count=15, o_Timeout=0.
REQ-030 Extra i_Start in RUN and i_Stop/i_Start in DONE -> no change to o_Count or o_Valid; i_Ack and i_Start in the same cycle in DONE -> IDLE, no new run.
REQ-031 i_Rst_n pulled low between clock edges mid-RUN -> all outputs 0 immediately; a new start/stop 12 cycles apart after release -> o_Count=12.
